// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter
//   Shares the register file's single write port between two writeback
//   requesters: ALU writeback (port A) and load/memory writeback (port B).
//   A one-bit round-robin pointer picks the winner when both request. The
//   winner is captured in a one-stage output register that drives the
//   register file write port and the read-side bypass port. A saturating
//   counter records the number of contended cycles.
//
// Ports
//   clock          : system clock, rising-edge active
//   reset          : asynchronous, active-high; clears all state
//   a_req/a_num/a_data, a_ready : ALU writeback request, accepted on a_req & a_ready
//   b_req/b_num/b_data, b_ready : memory writeback request, accepted on b_req & b_ready
//   WN, WD, RegWrite            : registered register-file write port
//   byp_valid/byp_num/byp_data  : bypass view of the output stage
//   conflict_count              : saturating count of cycles with a_req & b_req
module regwrite_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_req,
  input  logic [4:0]  a_num,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_req,
  input  logic [4:0]  b_num,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic [4:0]  WN,
  output logic [31:0] WD,
  output logic        RegWrite,
  output logic        byp_valid,
  output logic [4:0]  byp_num,
  output logic [31:0] byp_data,
  output logic [15:0] conflict_count
);

  localparam int NUM_W  = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic {
    PREF_A = 1'b0,
    PREF_B = 1'b1
  } pref_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  pref_t             ptr;
  pref_t             ptr_next;
  logic              grant_a;
  logic              grant_b;
  logic [NUM_W-1:0]  wn_p0;
  logic [DATA_W-1:0] wd_p0;
  logic              vld_p0;
  logic [NUM_W-1:0]  wn_p1;
  logic [DATA_W-1:0] wd_p1;
  logic              vld_p1;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;

  // Readiness never looks at the requester's own req, so a requester can
  // sample its ready before deciding to request without a combinational loop.
  assign a_ready = !b_req || (ptr == PREF_A);
  assign b_ready = !a_req || (ptr == PREF_B);
  assign grant_a = a_req && a_ready;
  assign grant_b = b_req && b_ready;

  always_comb begin
    ptr_next = ptr;
    wn_p0    = wn_p1;
    wd_p0    = wd_p1;
    vld_p0   = 1'b0;
    if (grant_a) begin
      ptr_next = PREF_B;
      wn_p0    = a_num;
      wd_p0    = a_data;
      vld_p0   = (a_num != '0);   // $0 completes the handshake but never writes
    end else if (grant_b) begin
      ptr_next = PREF_A;
      wn_p0    = b_num;
      wd_p0    = b_data;
      vld_p0   = (b_num != '0);
    end
  end

  assign cnt_next = (a_req && b_req) ? sat_inc(cnt) : cnt;

  // ---- stage p0 -> p1: output register feeding write port and bypass ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr    <= PREF_A;
      wn_p1  <= '0;
      wd_p1  <= '0;
      vld_p1 <= 1'b0;
      cnt    <= '0;
    end else begin
      ptr    <= ptr_next;
      wn_p1  <= wn_p0;
      wd_p1  <= wd_p0;
      vld_p1 <= vld_p0;
      cnt    <= cnt_next;
    end
  end

  assign WN             = wn_p1;
  assign WD             = wd_p1;
  assign RegWrite       = vld_p1;
  assign byp_valid      = vld_p1;
  assign byp_num        = wn_p1;
  assign byp_data       = wd_p1;
  assign conflict_count = cnt;

endmodule
